// File: rtl/aexm_enable_pkg.sv
// aexm_enable_pkg: shared types for the N-port enable sequencer.
// Sequencer state encoding and port-count ceiling.
package aexm_enable_pkg;

  localparam int NPORT_MAX = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    LDWB  = 2'd3
  } state_t;

endpackage

// File: rtl/aexm_enable_if.sv
// aexm_enable_if: pipeline/cache handshake bundle.
// master = cache/pipeline side, slave = sequencer side.
interface aexm_enable_if #(
  parameter int NPORT = 2
);

  logic             icache_busy;
  logic [NPORT-1:0] dcache_busy;
  logic [NPORT-1:0] dSTRLOD;
  logic [NPORT-1:0] dLOD;
  logic             cpu_enable;
  logic             cpu_mode_memop;
  logic             icache_enable;
  logic [NPORT-1:0] dcache_enable;

  modport master (
    output icache_busy, dcache_busy, dSTRLOD, dLOD,
    input  cpu_enable, cpu_mode_memop, icache_enable, dcache_enable
  );

  modport slave (
    input  icache_busy, dcache_busy, dSTRLOD, dLOD,
    output cpu_enable, cpu_mode_memop, icache_enable, dcache_enable
  );

endinterface

// File: rtl/aexm_enable_port.sv
// aexm_enable_port: per-port request/load tracking.
// A port is done once its cache drops busy while waiting.
module aexm_enable_port (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  input  logic issue,
  input  logic wait_st,
  input  logic kill,
  input  logic ldwb,
  input  logic dstrlod,
  input  logic dlod,
  input  logic busy,
  output logic req,
  output logic ld,
  output logic dcache_enable,
  output logic done
);

  assign dcache_enable = issue & req;
  assign done = ~(req & busy);

  // capture request, retire on completion/watchdog, drop load after write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      req <= 1'b0;
      ld  <= 1'b0;
    end else if (accept) begin
      req <= dstrlod;
      ld  <= dstrlod & dlod;
    end else if (wait_st) begin
      req <= req & busy & ~kill;
    end else if (ldwb) begin
      ld  <= 1'b0;
    end
  end

endmodule

// File: rtl/aexm_enable_nport.sv
// aexm_enable_nport: CPU/cache enable sequencer for NPORT dcache ports.
// Stalls the pipeline across a memop, with watchdog and stall counter.
module aexm_enable_nport
  import aexm_enable_pkg::*;
#(
  parameter int NPORT   = 2,
  parameter int TOUT_W  = 8,
  parameter int STALL_W = 16
) (
  input  logic               gclk,
  input  logic               grst,
  aexm_enable_if.slave       bus,
  input  logic [TOUT_W-1:0]  timeout_limit,
  input  logic               stall_clr,
  output logic               memop_timeout,
  output logic [STALL_W-1:0] stall_cycles
);

  state_t            state;
  logic [TOUT_W-1:0] wdog;
  logic [TOUT_W:0]   wdog_nx;
  logic [NPORT-1:0]  req;
  logic [NPORT-1:0]  ld;
  logic [NPORT-1:0]  den;
  logic [NPORT-1:0]  done;
  logic              run_st;
  logic              issue_st;
  logic              wait_st;
  logic              ldwb_st;
  logic              cpu_en;
  logic              accept;
  logic              all_done;
  logic              tout;

  assign run_st   = (state == RUN);
  assign issue_st = (state == ISSUE);
  assign wait_st  = (state == WAIT);
  assign ldwb_st  = (state == LDWB);

  assign cpu_en   = ~grst & run_st & ~bus.icache_busy;
  assign accept   = cpu_en & (|bus.dSTRLOD);
  assign all_done = &done;
  assign wdog_nx  = {1'b0, wdog} + (TOUT_W+1)'(1);
  assign tout     = wait_st & ~all_done
                  & (timeout_limit != '0)
                  & (wdog_nx == {1'b0, timeout_limit});

  assign bus.cpu_enable     = cpu_en;
  assign bus.icache_enable  = cpu_en;
  assign bus.cpu_mode_memop = ~grst & ~run_st;
  assign bus.dcache_enable  = den;

  for (genvar i = 0; i < NPORT; i++) begin : g_port
    aexm_enable_port u_port (
      .clk           (gclk),
      .rst           (grst),
      .accept        (accept),
      .issue         (~grst & issue_st),
      .wait_st       (wait_st),
      .kill          (tout),
      .ldwb          (ldwb_st),
      .dstrlod       (bus.dSTRLOD[i]),
      .dlod          (bus.dLOD[i]),
      .busy          (bus.dcache_busy[i]),
      .req           (req[i]),
      .ld            (ld[i]),
      .dcache_enable (den[i]),
      .done          (done[i])
    );
  end

  // memop sequencing, watchdog and sticky timeout flag
  always_ff @(posedge gclk) begin
    if (grst) begin
      state         <= RUN;
      wdog          <= '0;
      memop_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            state <= ISSUE;
            wdog  <= '0;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (all_done) begin
            state <= (|ld) ? LDWB : RUN;
          end else begin
            if (~&wdog) wdog <= wdog_nx[TOUT_W-1:0];
            if (tout) begin
              memop_timeout <= 1'b1;
              state         <= RUN;
            end
          end
        end
        LDWB:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // saturating count of stalled cycles; clear beats increment
  always_ff @(posedge gclk) begin
    if (grst || stall_clr) begin
      stall_cycles <= '0;
    end else if (~cpu_en && ~&stall_cycles) begin
      stall_cycles <= stall_cycles + STALL_W'(1);
    end
  end

  logic unused_ok;
  assign unused_ok = ^req;

endmodule

// File: tb/tb_aexm_enable_nport.sv
// tb_aexm_enable_nport: random memops vs transaction-level model.
// Scoreboard queue filled by stimulus, drained by an issue monitor.
module tb_aexm_enable_nport;

  typedef struct {
    logic [1:0] den;
    int         len;
    logic       tout;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  timeout_limit = '0;
  logic        stall_clr = 1'b0;
  logic        memop_timeout;
  logic [15:0] stall_cycles;

  int   n_vec = 0;
  int   n_miss = 0;
  int   stall_exp = 0;
  logic tout_sticky = 1'b0;
  bit   mon_en = 1'b0;
  exp_t q[$];

  aexm_enable_if #(.NPORT(2)) bus ();

  aexm_enable_nport #(.NPORT(2), .TOUT_W(8), .STALL_W(16)) dut (
    .gclk          (clk),
    .grst          (rst),
    .bus           (bus),
    .timeout_limit (timeout_limit),
    .stall_clr     (stall_clr),
    .memop_timeout (memop_timeout),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int sat(int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic logic [3:0] outs();
    return {bus.cpu_enable, bus.icache_enable,
            bus.cpu_mode_memop, |bus.dcache_enable};
  endfunction

  task automatic rnd_in();
    bus.icache_busy = 1'($urandom);
    bus.dSTRLOD     = 2'($urandom);
    bus.dLOD        = 2'($urandom);
  endtask

  task automatic do_memop(input logic [1:0] rq, input logic [1:0] lod,
                          input int b0, input int b1, input int pre,
                          input logic [7:0] lim);
    int   mb;
    int   wc;
    logic to;
    exp_t e;
    timeout_limit = lim;
    repeat (pre) begin
      bus.icache_busy = 1'b1;
      bus.dSTRLOD     = rq;
      bus.dLOD        = lod;
      bus.dcache_busy = 2'($urandom);
      step();
      stall_exp = sat(stall_exp + 1);
    end
    mb = 0;
    if (rq[0] && b0 > mb) mb = b0;
    if (rq[1] && b1 > mb) mb = b1;
    to = (lim != 0) && (int'(lim) <= mb);
    wc = to ? int'(lim) : mb + 1;
    tout_sticky = tout_sticky | to;
    e.den  = rq;
    e.len  = 1 + wc + (((rq & lod) != 0 && !to) ? 1 : 0);
    e.tout = tout_sticky;
    q.push_back(e);
    bus.icache_busy = 1'b0;
    bus.dSTRLOD     = rq;
    bus.dLOD        = lod;
    bus.dcache_busy = 2'($urandom);
    step();
    rnd_in();
    bus.dcache_busy = 2'($urandom);
    step();
    for (int w = 0; w < wc; w++) begin
      rnd_in();
      bus.dcache_busy[0] = rq[0] ? (w < b0) : 1'($urandom);
      bus.dcache_busy[1] = rq[1] ? (w < b1) : 1'($urandom);
      step();
    end
    if (e.len > 1 + wc) begin
      rnd_in();
      bus.dcache_busy = 2'($urandom);
      step();
    end
    stall_exp = sat(stall_exp + e.len);
    bus.icache_busy = 1'b0;
    bus.dSTRLOD     = '0;
    bus.dLOD        = '0;
    bus.dcache_busy = '0;
    step();
  endtask

  exp_t m_e;
  int   m_len;
  bit   m_ok;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst && bus.dcache_enable != 0) begin
        if (q.size() == 0) begin
          chk("spurious_issue", 32'(bus.dcache_enable), 0);
        end else begin
          m_e   = q.pop_front();
          m_len = 1;
          m_ok  = bus.cpu_mode_memop && !bus.cpu_enable;
          chk("issue_mask", 32'(bus.dcache_enable), 32'(m_e.den));
          for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (bus.cpu_enable) break;
            m_len++;
            if (!bus.cpu_mode_memop || bus.dcache_enable != 0) m_ok = 0;
          end
          chk("stall_len", 32'(m_len), 32'(m_e.len));
          chk("memop_mode", 32'(m_ok), 1);
          chk("timeout_flag", 32'(memop_timeout), 32'(m_e.tout));
        end
      end
    end
  end

  initial begin
    bus.icache_busy = 1'b0;
    bus.dcache_busy = '0;
    bus.dSTRLOD     = '0;
    bus.dLOD        = '0;
    repeat (3) begin
      step();
      @(negedge clk);
      chk("reset_outs", 32'(outs()), 0);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_run", 32'(bus.cpu_enable), 1);
    chk("post_rst_stall", 32'(stall_cycles), 0);

    // reset while a memop is waiting
    step();
    bus.dSTRLOD = 2'b01;
    step();
    bus.dSTRLOD = 2'b00;
    step();
    bus.dcache_busy = 2'b01;
    step();
    step();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_wait_rst_outs", 32'(outs()), 0);
      step();
    end
    rst = 1'b0;
    bus.dcache_busy = '0;
    @(negedge clk);
    chk("rst_abandon_run", 32'(bus.cpu_enable), 1);
    chk("rst_abandon_stall", 32'(stall_cycles), 0);
    chk("rst_abandon_tout", 32'(memop_timeout), 0);
    step();
    stall_exp = 0;
    mon_en = 1'b1;

    // saturating stall counter, then clear
    bus.icache_busy = 1'b1;
    repeat (70000) begin
      step();
      stall_exp = sat(stall_exp + 1);
    end
    @(negedge clk);
    chk("stall_saturate", 32'(stall_cycles), 32'hFFFF);
    step();
    bus.icache_busy = 1'b0;
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    @(negedge clk);
    chk("stall_clear", 32'(stall_cycles), 0);
    stall_exp = 0;

    do_memop(2'b01, 2'b00, 0, 0, 0, 8'd0);
    do_memop(2'b11, 2'b10, 1, 4, 0, 8'd0);
    do_memop(2'b01, 2'b00, 0, 0, 2, 8'd0);
    do_memop(2'b01, 2'b01, 20, 0, 0, 8'd0);
    do_memop(2'b01, 2'b00, 50, 0, 0, 8'd4);
    do_memop(2'b10, 2'b10, 0, 3, 0, 8'd3);

    for (int t = 0; t < 60; t++) begin
      do_memop(2'($urandom_range(1, 3)), 2'($urandom),
               $urandom_range(0, 6), $urandom_range(0, 6),
               $urandom_range(0, 2),
               ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 8)));
      repeat ($urandom_range(0, 3)) begin
        bus.icache_busy = 1'($urandom);
        if (bus.icache_busy) stall_exp = sat(stall_exp + 1);
        step();
      end
      bus.icache_busy = 1'b0;
    end

    repeat (4) step();
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    chk("stall_total", 32'(stall_cycles), 32'(stall_exp));
    chk("timeout_sticky", 32'(memop_timeout), 32'(tout_sticky));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
